// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    VEC_HI,
    VEC_LO,
    FETCH,
    FETCH_IMM
  } fetch_state_t;

  localparam logic [2:0] TWO_WORD_PREFIX = 3'b110;

  // Reset vector: high half at RESET_VEC_HI_ADDR, low half at the next word.
  localparam int RESET_VEC_HI_ADDR = 0;
  localparam int RESET_VEC_LO_OFS  = 1;

  function automatic logic is_two_word(input logic [2:0] top_bits);
    return top_bits == TWO_WORD_PREFIX;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load has priority over increment, otherwise holds.
// Updates on the rising edge; no backpressure of its own, the caller gates load/inc.
module fetch_pc_reg #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: loads PC from the reset vector, assembles 1/2-word instructions into a registered packet.
// Packet appears one edge after its last word is read; stall holds everything, redirect wins over stall.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int INSTR_WIDTH     = 16,
  parameter int PC_WIDTH        = 32,
  parameter int IMEM_ADDR_WIDTH = 21,
  parameter int RESET_VEC_ADDR  = RESET_VEC_HI_ADDR
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_data,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  output logic [PC_WIDTH-1:0]        pc,
  output logic [INSTR_WIDTH-1:0]     fd_instr,
  output logic [INSTR_WIDTH-1:0]     fd_imm,
  output logic [PC_WIDTH-1:0]        fd_pc,
  output logic                       fd_valid
);

  fetch_state_t state, state_nxt;

  logic [INSTR_WIDTH-1:0] pending, pending_nxt;
  logic [PC_WIDTH-1:0]    pending_pc, pending_pc_nxt;

  logic [INSTR_WIDTH-1:0] fd_instr_nxt, fd_imm_nxt;
  logic [PC_WIDTH-1:0]    fd_pc_nxt;
  logic                   fd_valid_nxt;

  logic                pc_load;
  logic                pc_inc;
  logic [PC_WIDTH-1:0] pc_load_val;

  fetch_pc_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= VEC_HI;
      pending    <= '0;
      pending_pc <= '0;
      fd_instr   <= '0;
      fd_imm     <= '0;
      fd_pc      <= '0;
      fd_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      pending_pc <= pending_pc_nxt;
      fd_instr   <= fd_instr_nxt;
      fd_imm     <= fd_imm_nxt;
      fd_pc      <= fd_pc_nxt;
      fd_valid   <= fd_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pending_nxt    = pending;
    pending_pc_nxt = pending_pc;
    fd_instr_nxt   = fd_instr;
    fd_imm_nxt     = fd_imm;
    fd_pc_nxt      = fd_pc;
    fd_valid_nxt   = fd_valid;
    pc_load        = 1'b0;
    pc_inc         = 1'b0;
    pc_load_val    = redirect_pc;
    imem_addr      = pc[IMEM_ADDR_WIDTH-1:0];

    case (state)
      VEC_HI: begin
        imem_addr   = IMEM_ADDR_WIDTH'(RESET_VEC_ADDR);
        pc_load     = 1'b1;
        pc_load_val = {imem_data, pc[INSTR_WIDTH-1:0]};
        state_nxt   = VEC_LO;
      end
      VEC_LO: begin
        imem_addr   = IMEM_ADDR_WIDTH'(RESET_VEC_ADDR + RESET_VEC_LO_OFS);
        pc_load     = 1'b1;
        pc_load_val = {pc[PC_WIDTH-1:INSTR_WIDTH], imem_data};
        state_nxt   = FETCH;
      end
      FETCH, FETCH_IMM: begin
        if (redirect) begin
          // Any half-assembled two-word instruction is simply abandoned.
          pc_load      = 1'b1;
          fd_valid_nxt = 1'b0;
          state_nxt    = FETCH;
        end else if (!stall) begin
          pc_inc = 1'b1;
          if (state == FETCH_IMM) begin
            fd_instr_nxt = pending;
            fd_imm_nxt   = imem_data;
            fd_pc_nxt    = pending_pc;
            fd_valid_nxt = 1'b1;
            state_nxt    = FETCH;
          end else if (is_two_word(imem_data[INSTR_WIDTH-1 -: 3])) begin
            pending_nxt    = imem_data;
            pending_pc_nxt = pc;
            fd_valid_nxt   = 1'b0;
            state_nxt      = FETCH_IMM;
          end else begin
            fd_instr_nxt = imem_data;
            fd_imm_nxt   = '0;
            fd_pc_nxt    = pc;
            fd_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = VEC_HI;
    endcase
  end

endmodule
